// File: rtl/run_seq_detector_pkg.sv
// Shared defaults, width helper and the run-length control bundle for the run sequence detector.
package run_seq_detector_pkg;

  localparam int unsigned DEF_SYM_W = 2;
  localparam int unsigned DEF_LEN   = 3;
  localparam logic [DEF_LEN*DEF_SYM_W-1:0] DEF_PAT = 6'b111001;

  // Bits needed to hold the values 0..n (never less than one bit).
  function automatic int unsigned cntw(input int unsigned n);
    cntw = (n < 2) ? 1 : $clog2(n + 1);
  endfunction

  typedef struct packed {
    logic inc;
    logic set;
    logic clr;
  } run_ctl_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with clear and load-one; shared by run length and match counting.
module sat_counter #(
  parameter int unsigned     WIDTH = 8,
  parameter logic [WIDTH-1:0] MAX  = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  input  logic             set,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] r_cnt;

  // clr outranks both set and inc
  always_ff @(posedge clk) begin
    if (reset || clr)              r_cnt <= '0;
    else if (set)                  r_cnt <= WIDTH'(1);
    else if (inc && r_cnt != MAX)  r_cnt <= r_cnt + WIDTH'(1);
  end

  assign count = r_cnt;

endmodule

// File: rtl/run_seq_detector.sv
// Detects LEN ordered runs of programmable symbols, each at least MIN_RUN long,
// with a level output, a rising-edge pulse and a saturating match counter.
module run_seq_detector
  import run_seq_detector_pkg::*;
#(
  parameter int unsigned SYM_W   = DEF_SYM_W,
  parameter int unsigned LEN     = DEF_LEN,
  parameter int unsigned MIN_RUN = 1,
  parameter int unsigned CNT_W   = 8,
  parameter logic [LEN*SYM_W-1:0] DEFAULT_PAT = DEF_PAT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [SYM_W-1:0]           sym,
  input  logic                       load,
  input  logic [LEN*SYM_W-1:0]       pattern,
  input  logic                       cnt_clr,
  output logic                       ans,
  output logic                       hit_pulse,
  output logic [$clog2(LEN+1)-1:0]   stage,
  output logic [CNT_W-1:0]           match_cnt
);

  localparam int unsigned SW = $clog2(LEN + 1);
  localparam int unsigned RW = cntw(MIN_RUN);

  logic [LEN*SYM_W-1:0] r_pat;
  logic [SW-1:0]        r_stage, w_stage_nxt;
  logic                 r_hit;
  logic [RW-1:0]        w_run_len, w_run_nxt;
  logic [SYM_W-1:0]     w_pat [2**SW];
  logic [SYM_W-1:0]     w_cur, w_nxt;
  logic                 w_run_ok, w_ans, w_ans_nxt;
  run_ctl_t             w_run_ctl;

  // Pad the element table to a power of two so the stage value indexes it directly.
  for (genvar k = 0; k < 2**SW; k++) begin : g_pat
    if (k < LEN) begin : g_used
      assign w_pat[k] = r_pat[k*SYM_W +: SYM_W];
    end else begin : g_pad
      assign w_pat[k] = '0;
    end
  end

  assign w_cur    = w_pat[r_stage - SW'(1)];
  assign w_nxt    = w_pat[r_stage];
  assign w_run_ok = (w_run_len >= RW'(MIN_RUN));
  assign w_ans    = (r_stage == SW'(LEN)) && w_run_ok;

  // Rule order matters: staying in a run shadows advancing, which shadows restarting.
  always_comb begin
    w_stage_nxt = r_stage;
    w_run_ctl   = '0;
    if (load) begin
      w_stage_nxt   = '0;
      w_run_ctl.clr = 1'b1;
    end else if (in_valid) begin
      if (r_stage != '0 && sym == w_cur) begin
        w_run_ctl.inc = 1'b1;
      end else if (r_stage != '0 && r_stage != SW'(LEN) && sym == w_nxt && w_run_ok) begin
        w_stage_nxt   = r_stage + SW'(1);
        w_run_ctl.set = 1'b1;
      end else if (sym == w_pat[0]) begin
        w_stage_nxt   = SW'(1);
        w_run_ctl.set = 1'b1;
      end else begin
        w_stage_nxt   = '0;
        w_run_ctl.clr = 1'b1;
      end
    end
  end

  // Look-ahead of the run counter so the pulse lands in the same cycle ans rises.
  always_comb begin
    w_run_nxt = w_run_len;
    if (w_run_ctl.clr)                   w_run_nxt = '0;
    else if (w_run_ctl.set)              w_run_nxt = RW'(1);
    else if (w_run_ctl.inc && !w_run_ok) w_run_nxt = w_run_len + RW'(1);
  end

  assign w_ans_nxt = (w_stage_nxt == SW'(LEN)) && (w_run_nxt >= RW'(MIN_RUN));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pat   <= DEFAULT_PAT;
      r_stage <= '0;
      r_hit   <= 1'b0;
    end else begin
      if (load) r_pat <= pattern;
      r_stage <= w_stage_nxt;
      r_hit   <= w_ans_nxt && !w_ans;
    end
  end

  sat_counter #(.WIDTH(RW), .MAX(RW'(MIN_RUN))) u_run (
    .clk   (clk),
    .reset (reset),
    .inc   (w_run_ctl.inc),
    .clr   (w_run_ctl.clr),
    .set   (w_run_ctl.set),
    .count (w_run_len)
  );

  sat_counter #(.WIDTH(CNT_W), .MAX({CNT_W{1'b1}})) u_match (
    .clk   (clk),
    .reset (reset),
    .inc   (r_hit),
    .clr   (cnt_clr),
    .set   (1'b0),
    .count (match_cnt)
  );

  assign ans       = w_ans;
  assign hit_pulse = r_hit;
  assign stage     = r_stage;

endmodule

// File: tb/tb_run_seq_detector.sv
// Directed bench: three detector variants (defaults, MIN_RUN=2, CNT_W=2) on shared inputs.
module tb_run_seq_detector;

  logic       clk = 1'b0;
  logic       reset = 1'b0, in_valid = 1'b0, load = 1'b0, cnt_clr = 1'b0;
  logic [1:0] sym = 2'd0;
  logic [5:0] pattern = 6'd0;
  int         n_cmp = 0, n_bad = 0;

  logic       a_ans, a_hit, b_ans, b_hit, c_ans, c_hit;
  logic [1:0] a_stage, b_stage, c_stage, c_cnt;
  logic [7:0] a_cnt, b_cnt;

  always #5 clk = ~clk;

  run_seq_detector u_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .sym(sym), .load(load),
    .pattern(pattern), .cnt_clr(cnt_clr), .ans(a_ans), .hit_pulse(a_hit),
    .stage(a_stage), .match_cnt(a_cnt));

  run_seq_detector #(.MIN_RUN(2)) u_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .sym(sym), .load(load),
    .pattern(pattern), .cnt_clr(cnt_clr), .ans(b_ans), .hit_pulse(b_hit),
    .stage(b_stage), .match_cnt(b_cnt));

  run_seq_detector #(.CNT_W(2)) u_c (
    .clk(clk), .reset(reset), .in_valid(in_valid), .sym(sym), .load(load),
    .pattern(pattern), .cnt_clr(cnt_clr), .ans(c_ans), .hit_pulse(c_hit),
    .stage(c_stage), .match_cnt(c_cnt));

  // One clock with the given inputs; outputs are sampled 1 time unit after the edge.
  task automatic step(input logic v, input logic [1:0] s);
    in_valid = v;
    sym      = s;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1'b0, 2'd0);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    sym = 2'd3;
    do_reset();
    n_cmp++; if (a_stage !== 2'd0) begin n_bad++; $display("FAIL reset_stage: got %0d want 0", a_stage); end
    n_cmp++; if (a_ans !== 1'b0)   begin n_bad++; $display("FAIL reset_ans: got %0d want 0", a_ans); end
    n_cmp++; if (a_hit !== 1'b0)   begin n_bad++; $display("FAIL reset_hit: got %0d want 0", a_hit); end
    n_cmp++; if (a_cnt !== 8'd0)   begin n_bad++; $display("FAIL reset_cnt: got %0d want 0", a_cnt); end
    n_cmp++; if (c_cnt !== 2'd0)   begin n_bad++; $display("FAIL reset_cnt_c: got %0d want 0", c_cnt); end
  endtask

  task automatic test_basic();
    do_reset();
    step(1'b1, 2'd1);
    n_cmp++; if (a_stage !== 2'd1) begin n_bad++; $display("FAIL t1_stage1: got %0d want 1", a_stage); end
    step(1'b1, 2'd1);
    step(1'b1, 2'd2);
    step(1'b1, 2'd2);
    n_cmp++; if (a_stage !== 2'd2) begin n_bad++; $display("FAIL t1_stage2: got %0d want 2", a_stage); end
    n_cmp++; if (a_ans !== 1'b0)   begin n_bad++; $display("FAIL t1_ans_pre: got %0d want 0", a_ans); end
    step(1'b1, 2'd3);
    n_cmp++; if (a_ans !== 1'b1)   begin n_bad++; $display("FAIL t1_ans: got %0d want 1", a_ans); end
    n_cmp++; if (a_hit !== 1'b1)   begin n_bad++; $display("FAIL t1_hit: got %0d want 1", a_hit); end
    n_cmp++; if (a_cnt !== 8'd0)   begin n_bad++; $display("FAIL t1_cnt_lag: got %0d want 0", a_cnt); end
    step(1'b0, 2'd0);
    n_cmp++; if (a_hit !== 1'b0)   begin n_bad++; $display("FAIL t1_hit_once: got %0d want 0", a_hit); end
    n_cmp++; if (a_ans !== 1'b1)   begin n_bad++; $display("FAIL t1_ans_hold: got %0d want 1", a_ans); end
    n_cmp++; if (a_cnt !== 8'd1)   begin n_bad++; $display("FAIL t1_cnt: got %0d want 1", a_cnt); end
  endtask

  // Continues from the hit left by test_basic.
  task automatic test_hold_and_break();
    step(1'b1, 2'd3);
    step(1'b1, 2'd3);
    n_cmp++; if (a_ans !== 1'b1)   begin n_bad++; $display("FAIL t2_ans_rep: got %0d want 1", a_ans); end
    n_cmp++; if (a_hit !== 1'b0)   begin n_bad++; $display("FAIL t2_no_pulse: got %0d want 0", a_hit); end
    step(1'b1, 2'd1);
    n_cmp++; if (a_ans !== 1'b0)   begin n_bad++; $display("FAIL t2_ans_1: got %0d want 0", a_ans); end
    n_cmp++; if (a_stage !== 2'd1) begin n_bad++; $display("FAIL t2_stage_1: got %0d want 1", a_stage); end
    step(1'b1, 2'd2);
    step(1'b1, 2'd3);
    n_cmp++; if (a_hit !== 1'b1)   begin n_bad++; $display("FAIL t2_rehit: got %0d want 1", a_hit); end
    step(1'b1, 2'd2);
    n_cmp++; if (a_ans !== 1'b0)   begin n_bad++; $display("FAIL t2_ans_2: got %0d want 0", a_ans); end
    n_cmp++; if (a_stage !== 2'd0) begin n_bad++; $display("FAIL t2_stage_0: got %0d want 0", a_stage); end
    n_cmp++; if (a_cnt !== 8'd2)   begin n_bad++; $display("FAIL t2_cnt: got %0d want 2", a_cnt); end
  endtask

  task automatic test_min_run();
    do_reset();
    step(1'b1, 2'd1);
    step(1'b1, 2'd2);
    n_cmp++; if (b_stage !== 2'd0) begin n_bad++; $display("FAIL t3_short: got %0d want 0", b_stage); end
    step(1'b1, 2'd1);
    step(1'b1, 2'd1);
    step(1'b1, 2'd2);
    step(1'b1, 2'd3);
    n_cmp++; if (b_stage !== 2'd0) begin n_bad++; $display("FAIL t3_short2_stage: got %0d want 0", b_stage); end
    n_cmp++; if (b_ans !== 1'b0)   begin n_bad++; $display("FAIL t3_short2_ans: got %0d want 0", b_ans); end
    step(1'b1, 2'd1);
    step(1'b1, 2'd1);
    step(1'b1, 2'd2);
    step(1'b1, 2'd2);
    step(1'b1, 2'd3);
    n_cmp++; if (b_stage !== 2'd3) begin n_bad++; $display("FAIL t3_stage3: got %0d want 3", b_stage); end
    n_cmp++; if (b_ans !== 1'b0)   begin n_bad++; $display("FAIL t3_ans_early: got %0d want 0", b_ans); end
    step(1'b1, 2'd3);
    n_cmp++; if (b_ans !== 1'b1)   begin n_bad++; $display("FAIL t3_ans: got %0d want 1", b_ans); end
    n_cmp++; if (b_hit !== 1'b1)   begin n_bad++; $display("FAIL t3_hit: got %0d want 1", b_hit); end
  endtask

  task automatic test_gaps();
    do_reset();
    step(1'b1, 2'd1);
    step(1'b0, 2'd2);
    step(1'b0, 2'd3);
    step(1'b0, 2'd0);
    n_cmp++; if (a_stage !== 2'd1) begin n_bad++; $display("FAIL t4_gap_stage: got %0d want 1", a_stage); end
    step(1'b1, 2'd2);
    step(1'b0, 2'd1);
    n_cmp++; if (a_stage !== 2'd2) begin n_bad++; $display("FAIL t4_gap_stage2: got %0d want 2", a_stage); end
    n_cmp++; if (a_hit !== 1'b0)   begin n_bad++; $display("FAIL t4_gap_hit: got %0d want 0", a_hit); end
    step(1'b1, 2'd3);
    n_cmp++; if (a_ans !== 1'b1)   begin n_bad++; $display("FAIL t4_ans: got %0d want 1", a_ans); end
    n_cmp++; if (a_hit !== 1'b1)   begin n_bad++; $display("FAIL t4_hit: got %0d want 1", a_hit); end
  endtask

  task automatic test_load();
    do_reset();
    step(1'b1, 2'd1);
    step(1'b1, 2'd2);
    load    = 1'b1;
    pattern = 6'b00_11_10;  // pat[0]=2, pat[1]=3, pat[2]=0
    step(1'b1, 2'd3);
    load    = 1'b0;
    n_cmp++; if (a_stage !== 2'd0) begin n_bad++; $display("FAIL t5_load_stage: got %0d want 0", a_stage); end
    step(1'b1, 2'd2);
    step(1'b1, 2'd3);
    step(1'b1, 2'd0);
    n_cmp++; if (a_ans !== 1'b1)   begin n_bad++; $display("FAIL t5_new_ans: got %0d want 1", a_ans); end
    n_cmp++; if (a_hit !== 1'b1)   begin n_bad++; $display("FAIL t5_new_hit: got %0d want 1", a_hit); end
    step(1'b1, 2'd1);
    step(1'b1, 2'd2);
    step(1'b1, 2'd3);
    n_cmp++; if (a_ans !== 1'b0)   begin n_bad++; $display("FAIL t5_old_ans: got %0d want 0", a_ans); end
    n_cmp++; if (a_stage !== 2'd2) begin n_bad++; $display("FAIL t5_old_stage: got %0d want 2", a_stage); end
    step(1'b1, 2'd0);
    n_cmp++; if (a_ans !== 1'b1)   begin n_bad++; $display("FAIL t5_ans_up: got %0d want 1", a_ans); end
    load = 1'b1;
    step(1'b0, 2'd0);
    load = 1'b0;
    n_cmp++; if (a_ans !== 1'b0)   begin n_bad++; $display("FAIL t5_load_drop: got %0d want 0", a_ans); end
  endtask

  task automatic test_saturate_and_reset();
    logic [1:0] exp_cnt;
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      step(1'b1, 2'd1);
      step(1'b1, 2'd2);
      step(1'b1, 2'd3);
      n_cmp++; if (c_hit !== 1'b1) begin n_bad++; $display("FAIL t6_hit%0d: got %0d want 1", k, c_hit); end
      step(1'b0, 2'd0);
      exp_cnt = (k < 3) ? 2'(k) : 2'd3;
      n_cmp++; if (c_cnt !== exp_cnt) begin n_bad++; $display("FAIL t6_cnt%0d: got %0d want %0d", k, c_cnt, exp_cnt); end
    end
    step(1'b1, 2'd1);
    step(1'b1, 2'd2);
    step(1'b1, 2'd3);
    cnt_clr = 1'b1;
    step(1'b0, 2'd0);
    cnt_clr = 1'b0;
    n_cmp++; if (c_cnt !== 2'd0)   begin n_bad++; $display("FAIL t6_clr_wins: got %0d want 0", c_cnt); end
    load    = 1'b1;
    pattern = 6'b00_11_10;
    step(1'b0, 2'd0);
    load    = 1'b0;
    step(1'b1, 2'd2);
    step(1'b1, 2'd3);
    n_cmp++; if (c_stage !== 2'd2) begin n_bad++; $display("FAIL t6_pre_stage: got %0d want 2", c_stage); end
    reset = 1'b1;
    step(1'b1, 2'd0);
    reset = 1'b0;
    n_cmp++; if (c_stage !== 2'd0) begin n_bad++; $display("FAIL t6_rst_stage: got %0d want 0", c_stage); end
    n_cmp++; if (c_ans !== 1'b0)   begin n_bad++; $display("FAIL t6_rst_ans: got %0d want 0", c_ans); end
    n_cmp++; if (c_hit !== 1'b0)   begin n_bad++; $display("FAIL t6_rst_hit: got %0d want 0", c_hit); end
    step(1'b1, 2'd1);
    step(1'b1, 2'd2);
    step(1'b1, 2'd3);
    n_cmp++; if (c_ans !== 1'b1)   begin n_bad++; $display("FAIL t6_default_pat: got %0d want 1", c_ans); end
  endtask

  initial begin
    #2;
    test_reset();
    test_basic();
    test_hold_and_break();
    test_min_run();
    test_gaps();
    test_load();
    test_saturate_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
